irq_sequencer: RTL
==================

Name: irq_sequencer

Overview:
- Interrupt controller and pipeline sequencer for the 8-bit pipelined processor.
- Latches edge-triggered requests from NUM_SRC sources, applies a mask register and fixed priority, then sequences the core:
  - stall fetch, drain in-flight stages, flush, load the vector PC;
  - service the handler; on RETI, flush and reload the saved return PC.
- Sits beside the fetch/PC stage. Its outputs override normal PC update.
- One interrupt is serviced at a time. There is no nesting.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..8).
- ID_W, 2, width of the source id, equal to $clog2(NUM_SRC).
- ADDR_W, 8, PC/address width.
- VEC_BASE, 8'hF0, base of the vector table. Vector for source i = VEC_BASE + 4*i, modulo 2^ADDR_W.
- DRAIN_CYCLES, 3, cycles fetch is held so in-flight instructions (decode..writeback) retire before redirect.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- irq_in, input, NUM_SRC, request lines, rising-edge sensitive.
- mask_we, input, 1, write strobe for the mask register.
- mask_wdata, input, NUM_SRC, mask data; 1 = source masked.
- current_address, input, ADDR_W, PC of the instruction currently in fetch.
- reti, input, 1, one-cycle pulse when a return-from-interrupt instruction retires.
- stall_fetch, output, 1, hold PC and IF register.
- flush, output, 1, kill IF/ID/EX contents this cycle.
- pc_load, output, 1, force PC <= pc_load_addr at the next edge.
- pc_load_addr, output, ADDR_W, forced PC value.
- in_service, output, 1, handler currently executing.
- active_id, output, ID_W, id of the source being serviced.
- pending, output, NUM_SRC, latched pending requests.
- mask_out, output, NUM_SRC, current mask register.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: all state updates only on the rising edge of clk while reset is high.
  - Reset values: state = IDLE; stall_fetch, flush, pc_load, in_service = 0; pc_load_addr = 0; active_id = 0; pending = 0; mask = all ones (all masked); drain counter = 0; saved return address = 0.
  - During reset, irq_prev <= irq_in, so a line already high gives no false edge after release.
  - Reset mid-sequence (any state) aborts to IDLE with the values above.
  - All outputs are registered or decoded from the state register. No combinational input-to-output path.
- Edge capture:
  - Each cycle irq_prev <= irq_in.
  - pending[i] is set when irq_in[i] & ~irq_prev[i].
  - pending[i] is cleared when source i is accepted.
  - A set and a clear on the same bit in the same cycle resolve to set (new event kept).
- Mask:
  - mask_we writes mask_wdata at the edge.
  - The new mask affects eligibility from the next cycle.
  - Masked sources still latch pending.
- Eligibility and priority:
  - eligible = pending & ~mask.
  - Lowest index has highest priority.
- FSM states and transitions:
  - IDLE: if eligible != 0, select the winner and move to DRAIN at that edge. Same edge: active_id <= winner, ret_addr <= current_address, pending[winner] cleared, drain counter <= DRAIN_CYCLES-1.
  - DRAIN: stall_fetch=1. The counter decrements each cycle; at 0, go to VECTOR. The state lasts exactly DRAIN_CYCLES cycles.
  - VECTOR: one cycle. stall_fetch=1, flush=1, pc_load=1, pc_load_addr = VEC_BASE + 4*active_id.
  - SERVICE: in_service=1 and all other controls 0. Stays until reti=1, then goes to RETURN. New requests only accumulate in pending.
  - RETURN: one cycle. flush=1, pc_load=1, pc_load_addr = ret_addr, in_service=0. Next state is IDLE.
  - IDLE may re-accept a pending source on the cycle after RETURN, giving back-to-back service.
- Latency: a rising edge sampled at edge k sets pending after k. Acceptance happens at edge k+1. pc_load=1 is visible in the cycle after edge k+1+DRAIN_CYCLES, i.e. 2+DRAIN_CYCLES edges from the irq edge when unmasked and idle.
- Boundaries and ignored inputs:
  - reti outside SERVICE is ignored.
  - A mask change while in DRAIN/VECTOR/SERVICE does not cancel the accepted interrupt.
  - Vector address wraps modulo 2^ADDR_W.

Test Plan:
- Reset check: assert reset 2 cycles with irq_in=4'b0100 held -> after release, all outputs 0, mask_out=4'hF, pending=0, no pending set while the line stays high.
- Single IRQ, default parameters:
  - Stimulus: write mask=4'h0; current_address=8'h23; pulse irq_in[2].
  - Required: stall_fetch high 3 cycles, then a 1-cycle pc_load/flush with pc_load_addr=8'hF8; in_service=1, active_id=2.
  - Then pulse reti -> 1-cycle pc_load with pc_load_addr=8'h23, then IDLE.
- Priority: with mask=0, raise irq_in[3] and irq_in[1] on the same edge.
  - Required: source 1 is serviced first (vector 8'hF4), pending=4'b1000 during service.
  - After reti, source 3 is accepted the next cycle (vector 8'hFC).
- Masking: mask=4'b0001, pulse irq_in[0] -> pending[0]=1, no stall. Write mask=0 -> acceptance on the following edge.
- Ignored and repeated events:
  - reti pulse during DRAIN and during IDLE -> no state change.
  - A new irq_in[2] edge during SERVICE of source 2 -> pending[2]=1, serviced again after RETURN.
- Reset mid-operation: assert reset during SERVICE -> next cycle IDLE, in_service=0, pending=0, mask=4'hF, no pc_load.

Source files
------------

// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if: core-side request/mask/PC inputs (irq_in, mask_we, mask_wdata, current_address, reti) and sequencer controls (stall_fetch, flush, pc_load, pc_load_addr, in_service, active_id, pending, mask_out)
interface irq_sequencer_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W = 2,
  parameter int ADDR_W = 8
);
  logic [NUM_SRC-1:0] irq_in;
  logic mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [ADDR_W-1:0] current_address;
  logic reti;
  logic stall_fetch;
  logic flush;
  logic pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic in_service;
  logic [ID_W-1:0] active_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask_out;
  modport master (
    output irq_in, mask_we, mask_wdata, current_address, reti,
    input stall_fetch, flush, pc_load, pc_load_addr, in_service, active_id, pending, mask_out
  );
  modport slave (
    input irq_in, mask_we, mask_wdata, current_address, reti,
    output stall_fetch, flush, pc_load, pc_load_addr, in_service, active_id, pending, mask_out
  );
endinterface

// File: rtl/irq_sequencer.sv
// irq_sequencer: edge-latched masked fixed-priority interrupt sequencer (clk, reset, bus: irq/mask/pc/reti in, stall/flush/pc_load/service status out)
module irq_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int ID_W = 2,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] VEC_BASE = 8'hF0,
  parameter int DRAIN_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  irq_sequencer_if.slave bus
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DRAIN = 3'd1;
  localparam logic [2:0] VECTOR = 3'd2;
  localparam logic [2:0] SERVICE = 3'd3;
  localparam logic [2:0] RETURN = 3'd4;
  logic [2:0] state;
  logic [NUM_SRC-1:0] irq_prev, pending, mask, eligible, rise, clr;
  logic [ID_W-1:0] active_id, winner;
  logic [ADDR_W-1:0] ret_addr;
  logic [CW-1:0] cnt;
  always_comb begin
    eligible = pending & ~mask;
    rise = bus.irq_in & ~irq_prev;
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) winner = eligible[i] ? ID_W'(i) : winner;
    clr = (state == IDLE && |eligible) ? (NUM_SRC'(1) << winner) : '0;
  end
  always_ff @(posedge clk) begin
    irq_prev <= bus.irq_in;
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      mask <= '1;
      active_id <= '0;
      ret_addr <= '0;
      cnt <= '0;
    end else begin
      // a fresh edge on a bit being accepted this cycle survives the clear
      pending <= (pending & ~clr) | rise;
      if (bus.mask_we) mask <= bus.mask_wdata;
      case (state)
        IDLE: if (|eligible) begin
          state <= DRAIN;
          active_id <= winner;
          ret_addr <= bus.current_address;
          cnt <= CW'(DRAIN_CYCLES - 1);
        end
        DRAIN: if (cnt == '0) state <= VECTOR; else cnt <= cnt - CW'(1);
        VECTOR: state <= SERVICE;
        SERVICE: if (bus.reti) state <= RETURN;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.stall_fetch = state == DRAIN || state == VECTOR;
  assign bus.flush = state == VECTOR || state == RETURN;
  assign bus.pc_load = state == VECTOR || state == RETURN;
  assign bus.pc_load_addr = state == VECTOR ? VEC_BASE + (ADDR_W'(active_id) << 2) : state == RETURN ? ret_addr : '0;
  assign bus.in_service = state == SERVICE;
  assign bus.active_id = active_id;
  assign bus.pending = pending;
  assign bus.mask_out = mask;
endmodule
